// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants and state encoding for the cache memory responder
package cache_pkg;

    localparam int DEF_ADDRESS_WIDTH   = 64;
    localparam int DEF_WRITE_DATA      = 64;
    localparam int DEF_BLOCK_SIZE_BITS = 6;
    localparam int DEF_DEPTH_BITS      = 4;
    localparam int DEF_LATENCY         = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RD_RESP = 2'd2,
        WR_DONE = 2'd3
    } resp_state_t;

endpackage

// File: rtl/cache_mem_responder_if.sv
// rtl/cache_mem_responder_if.sv - request/response bus between a cache and the memory responder
// Signals:
//   i_mem_valid, i_mem_rd_wr, i_mem_address, i_mem_write_data, i_mem_read_ready : requester -> responder
//   o_mem_ready, o_mem_read_data, o_mem_read_valid, o_rd_count, o_wr_count     : responder -> requester
// Modports: master (requester side), slave (responder side).
interface cache_mem_responder_if
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int WRITE_DATA    = DEF_WRITE_DATA
);

    logic                      i_mem_valid;
    logic                      i_mem_rd_wr;
    logic [ADDRESS_WIDTH-1:0]  i_mem_address;
    logic [WRITE_DATA*8-1:0]   i_mem_write_data;
    logic                      o_mem_ready;
    logic [WRITE_DATA*8-1:0]   o_mem_read_data;
    logic                      o_mem_read_valid;
    logic                      i_mem_read_ready;
    logic [31:0]               o_rd_count;
    logic [31:0]               o_wr_count;

    modport master (
        output i_mem_valid, i_mem_rd_wr, i_mem_address, i_mem_write_data, i_mem_read_ready,
        input  o_mem_ready, o_mem_read_data, o_mem_read_valid, o_rd_count, o_wr_count
    );

    modport slave (
        input  i_mem_valid, i_mem_rd_wr, i_mem_address, i_mem_write_data, i_mem_read_ready,
        output o_mem_ready, o_mem_read_data, o_mem_read_valid, o_rd_count, o_wr_count
    );

endinterface

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - fixed-latency block memory answering one cache request at a time
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears FSM, outputs, counters and all storage)
//   mem   : slave side of cache_mem_responder_if (request in, write-done pulse / read data out,
//           completed read and write counters)
module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
    parameter int WRITE_DATA      = DEF_WRITE_DATA,
    parameter int BLOCK_SIZE_BITS = DEF_BLOCK_SIZE_BITS,
    parameter int DEPTH_BITS      = DEF_DEPTH_BITS,
    parameter int LATENCY         = DEF_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_mem_responder_if.slave mem
);

    localparam int DATA_W = WRITE_DATA * 8;
    localparam int DEPTH  = 2 ** DEPTH_BITS;

    resp_state_t            state;
    resp_state_t            next_state;
    logic [3:0]             cnt;
    logic                   is_wr;
    logic [DEPTH_BITS-1:0]  idx;
    logic [DATA_W-1:0]      wdata;
    logic [DATA_W-1:0]      read_data;
    logic [31:0]            rd_count;
    logic [31:0]            wr_count;
    logic [DATA_W-1:0]      storage [DEPTH];

    // BUSY is left on the edge where the counter has already reached zero,
    // so loading LATENCY-1 gives exactly LATENCY cycles in BUSY.
    logic busy_done;
    assign busy_done = (state == BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mem.i_mem_valid)      next_state = BUSY;
            BUSY:    if (cnt == 4'd0)          next_state = is_wr ? WR_DONE : RD_RESP;
            RD_RESP: if (mem.i_mem_read_ready) next_state = IDLE;
            WR_DONE:                           next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            is_wr     <= 1'b0;
            idx       <= '0;
            wdata     <= '0;
            read_data <= '0;
            rd_count  <= 32'd0;
            wr_count  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem.i_mem_valid) begin
                        is_wr <= mem.i_mem_rd_wr;
                        idx   <= mem.i_mem_address[BLOCK_SIZE_BITS +: DEPTH_BITS];
                        wdata <= mem.i_mem_write_data;
                        cnt   <= 4'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (is_wr) begin
                        wr_count <= wr_count + 32'd1;
                    end else begin
                        read_data <= storage[idx];
                    end
                end
                RD_RESP: begin
                    if (mem.i_mem_read_ready) begin
                        rd_count <= rd_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (busy_done && is_wr) begin
            storage[idx] <= wdata;
        end
    end

    assign mem.o_mem_ready      = (state == WR_DONE);
    assign mem.o_mem_read_valid = (state == RD_RESP);
    assign mem.o_mem_read_data  = read_data;
    assign mem.o_rd_count       = rd_count;
    assign mem.o_wr_count       = wr_count;

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - directed self-checking bench for cache_mem_responder
module tb_cache_mem_responder;

    localparam int DW = 512;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    cache_mem_responder_if #(.ADDRESS_WIDTH(64), .WRITE_DATA(64)) bus ();

    cache_mem_responder #(
        .ADDRESS_WIDTH(64),
        .WRITE_DATA(64),
        .BLOCK_SIZE_BITS(6),
        .DEPTH_BITS(4),
        .LATENCY(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request just after an edge; the next edge is the acceptance edge T.
    // Returns #1 after T with i_mem_valid dropped unless hold is set.
    task automatic accept(input logic rw, input logic [63:0] addr, input logic [DW-1:0] data,
                          input logic hold);
        bus.i_mem_valid      = 1'b1;
        bus.i_mem_rd_wr      = rw;
        bus.i_mem_address    = addr;
        bus.i_mem_write_data = data;
        @(posedge clk);
        #1;
        if (!hold) bus.i_mem_valid = 1'b0;
    endtask

    logic [DW-1:0] a5_pat;

    initial begin
        tests  = 0;
        failed = 0;
        a5_pat = {64{8'hA5}};
        rst_n  = 1'b0;
        bus.i_mem_valid      = 1'b0;
        bus.i_mem_rd_wr      = 1'b0;
        bus.i_mem_address    = '0;
        bus.i_mem_write_data = '0;
        bus.i_mem_read_ready = 1'b1;

        tick(2);
        check("reset_ready", DW'(bus.o_mem_ready), '0);
        check("reset_rvalid", DW'(bus.o_mem_read_valid), '0);
        check("reset_rdata", bus.o_mem_read_data, '0);
        check("reset_rdcnt", DW'(bus.o_rd_count), '0);
        check("reset_wrcnt", DW'(bus.o_wr_count), '0);
        rst_n = 1'b1;

        // Read of unwritten 0x40 right after reset, ready held high
        accept(1'b0, 64'h40, '0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check("rd0_busy_valid", DW'(bus.o_mem_read_valid), '0);
        end
        tick(1);
        check("rd0_valid", DW'(bus.o_mem_read_valid), DW'(1));
        check("rd0_data", bus.o_mem_read_data, '0);
        check("rd0_noready", DW'(bus.o_mem_ready), '0);
        tick(1);
        check("rd0_valid_drop", DW'(bus.o_mem_read_valid), '0);
        check("rd0_count", DW'(bus.o_rd_count), DW'(1));

        // Write A5 pattern to 0x1C0, then read back
        accept(1'b1, 64'h1C0, a5_pat, 1'b0);
        tick(3);
        check("wr_a5_early_ready", DW'(bus.o_mem_ready), '0);
        tick(1);
        check("wr_a5_ready", DW'(bus.o_mem_ready), DW'(1));
        check("wr_a5_novalid", DW'(bus.o_mem_read_valid), '0);
        tick(1);
        check("wr_a5_ready_drop", DW'(bus.o_mem_ready), '0);
        check("wr_a5_count", DW'(bus.o_wr_count), DW'(1));
        accept(1'b0, 64'h1C0, '0, 1'b0);
        tick(4);
        check("rd_a5_valid", DW'(bus.o_mem_read_valid), DW'(1));
        check("rd_a5_data", bus.o_mem_read_data, a5_pat);
        tick(1);
        check("rd_a5_count", DW'(bus.o_rd_count), DW'(2));

        // Read with ready low for three cycles: response must hold
        bus.i_mem_read_ready = 1'b0;
        accept(1'b0, 64'h1C0, '0, 1'b0);
        tick(4);
        check("stall_valid0", DW'(bus.o_mem_read_valid), DW'(1));
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_valid", DW'(bus.o_mem_read_valid), DW'(1));
            check("stall_data", bus.o_mem_read_data, a5_pat);
            check("stall_count", DW'(bus.o_rd_count), DW'(2));
        end
        bus.i_mem_read_ready = 1'b1;
        tick(1);
        check("stall_release_valid", DW'(bus.o_mem_read_valid), '0);
        check("stall_release_count", DW'(bus.o_rd_count), DW'(3));

        // Aliasing: 0x43F has index 0 (high bit and offset bits ignored)
        accept(1'b1, 64'h43F, DW'(16'h1234), 1'b0);
        tick(5);
        check("alias_wr_count", DW'(bus.o_wr_count), DW'(2));
        accept(1'b0, 64'h000, '0, 1'b0);
        tick(4);
        check("alias_rd_data", bus.o_mem_read_data, DW'(16'h1234));
        check("alias_rd_noready", DW'(bus.o_mem_ready), '0);
        tick(1);
        accept(1'b0, 64'h040, '0, 1'b0);
        tick(4);
        check("alias_idx1_data", bus.o_mem_read_data, '0);
        tick(1);
        check("alias_rd_count", DW'(bus.o_rd_count), DW'(5));

        // Reset during BUSY of a write aborts it
        accept(1'b1, 64'h80, DW'(16'hDEAD), 1'b0);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("abort_async_wrcnt", DW'(bus.o_wr_count), '0);
        check("abort_async_rdcnt", DW'(bus.o_rd_count), '0);
        check("abort_async_data", bus.o_mem_read_data, '0);
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("abort_no_ready", DW'(bus.o_mem_ready), '0);
        end
        accept(1'b0, 64'h80, '0, 1'b0);
        tick(4);
        check("abort_rd_valid", DW'(bus.o_mem_read_valid), DW'(1));
        check("abort_rd_data", bus.o_mem_read_data, '0);
        tick(1);
        check("abort_wrcnt", DW'(bus.o_wr_count), '0);
        check("abort_rdcnt", DW'(bus.o_rd_count), DW'(1));

        // Held write valid: re-accepted every LATENCY+2 cycles
        accept(1'b1, 64'h100, DW'(8'h77), 1'b1);
        tick(4);
        check("hold_ready1", DW'(bus.o_mem_ready), DW'(1));
        check("hold_cnt1", DW'(bus.o_wr_count), DW'(1));
        tick(6);
        check("hold_ready2", DW'(bus.o_mem_ready), DW'(1));
        check("hold_cnt2", DW'(bus.o_wr_count), DW'(2));
        tick(6);
        check("hold_ready3", DW'(bus.o_mem_ready), DW'(1));
        check("hold_cnt3", DW'(bus.o_wr_count), DW'(3));
        bus.i_mem_valid = 1'b0;
        tick(6);
        check("hold_end_ready", DW'(bus.o_mem_ready), '0);
        check("hold_end_cnt", DW'(bus.o_wr_count), DW'(3));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 64, address bits.
REQ-002 SHALL have parameter WRITE_DATA, default 64, data bytes; the data bus is WRITE_DATA*8 bits.
REQ-003 SHALL have parameter BLOCK_SIZE_BITS, default 6, the byte-offset bits that are ignored for indexing.
REQ-004 SHALL have parameter DEPTH_BITS, default 4, the index bits; storage is 2**DEPTH_BITS blocks.
REQ-005 SHALL have parameter LATENCY, default 4, the wait cycles per request; legal range 1..15.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_mem_valid, input, 1 bit: request present.
REQ-009 SHALL have port i_mem_rd_wr, input, 1 bit: 0 = read, 1 = write.
REQ-010 SHALL have port i_mem_address, input, ADDRESS_WIDTH bits: request address.
REQ-011 SHALL have port i_mem_write_data, input, WRITE_DATA*8 bits: write block.
REQ-012 SHALL have port o_mem_ready, output, 1 bit: one-cycle write-complete pulse.
REQ-013 SHALL have port o_mem_read_data, output, WRITE_DATA*8 bits: read block.
REQ-014 SHALL have port o_mem_read_valid, output, 1 bit: read data valid.
REQ-015 SHALL have port i_mem_read_ready, input, 1 bit: requester accepts read data.
REQ-016 SHALL have port o_rd_count, output, 32 bits: completed reads, wrapping.
REQ-017 SHALL have port o_wr_count, output, 32 bits: completed writes, wrapping.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, BUSY, RD_RESP and WR_DONE.
REQ-019 In IDLE with i_mem_valid=1 at edge T, SHALL capture rd_wr, the address index and the write data, load the counter with LATENCY-1, and go to BUSY.
REQ-020 Index SHALL be i_mem_address[BLOCK_SIZE_BITS +: DEPTH_BITS]; higher bits SHALL be ignored (addresses alias), and offset bits SHALL be ignored.
REQ-021 BUSY SHALL decrement the counter each cycle and leave when the counter is 0; total BUSY time SHALL be exactly LATENCY cycles.
REQ-022 On a write leaving BUSY, SHALL update storage[index] with the captured data, assert o_mem_ready for exactly one cycle (state WR_DONE, cycle T+LATENCY+1), increment o_wr_count, and then return to IDLE.
REQ-023 On a read leaving BUSY, SHALL drive o_mem_read_data=storage[index] and o_mem_read_valid=1 from cycle T+LATENCY+1 in RD_RESP.
REQ-024 RD_RESP SHALL hold o_mem_read_data and o_mem_read_valid stable until an edge with i_mem_read_ready=1; at that edge SHALL increment o_rd_count and go to IDLE, with valid low the next cycle.
REQ-025 Inputs SHALL be ignored outside IDLE; there is no pipelining, and at most one request is outstanding.
REQ-026 i_mem_valid still high on return to IDLE SHALL be accepted as a new request (a re-presented write rewrites identical data, which is harmless).
REQ-027 Minimum write turnaround SHALL be LATENCY+2 cycles from acceptance edge to the next acceptance edge.
REQ-028 A read following a write to the same index SHALL return the new data.
REQ-029 o_mem_ready SHALL never assert for reads, and o_mem_read_valid SHALL never assert for writes.
REQ-030 Counters SHALL wrap from 2**32-1 to 0.

Reset
REQ-031 rst_n low SHALL immediately (asynchronously) force: state IDLE, counter 0, o_mem_ready 0, o_mem_read_valid 0, o_mem_read_data 0, o_rd_count 0, o_wr_count 0, all storage blocks 0.
REQ-032 Reset mid-operation SHALL abort the request: no storage update, no response, no count.
REQ-033 The first request SHALL be accepted at the first rising edge after rst_n deasserts with i_mem_valid=1.

Structure
REQ-034 Shared package cache_pkg SHALL hold the default parameter constants and the responder state encoding (IDLE=0, BUSY=1, RD_RESP=2, WR_DONE=3).
REQ-035 A single flat module SHALL be used with no sub-modules; storage SHALL be a reg array with a synchronous write port and a registered read.

Verification (LATENCY=4, DEPTH_BITS=4)
REQ-036 Reset then read of address 0x40 with ready held at 1 -> read_valid is 1 at cycle T+5 only, data = 0, and o_rd_count = 1.
REQ-037 Write 0xA5-pattern block to 0x1C0, then read 0x1C0 -> ready pulses at T+5; the read returns the 0xA5 pattern; o_wr_count = 1.
REQ-038 Read with i_mem_read_ready low for 3 cycles -> data and valid stay stable for 4 cycles; the count increments once.
REQ-039 Write to 0x400 (index 0) with data 0x1234, then read 0x000 -> returns 0x1234 (aliasing); the offset bits 0x3F are ignored.
REQ-040 Assert rst_n low during BUSY of a write -> no ready pulse; a subsequent read of that address returns 0; counts stay 0.
REQ-041 Hold i_mem_valid=1 with a write through completion -> re-accepted at the edge after WR_DONE; o_wr_count increments every 6 cycles.
